// File: rtl/exe_hazard_fwd_ctrl.sv
// EXE-stage operand forwarding, load-use/RAW stall, branch flush and
// data-memory freeze control, driven by a shadow copy of E/M/W dests.
module exe_hazard_fwd_ctrl #(
    parameter int REG_W = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             fwd_en,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_src1,
    input  logic [REG_W-1:0] id_src2,
    input  logic             id_use1,
    input  logic             id_use2,
    input  logic [REG_W-1:0] id_dest,
    input  logic             id_wb_en,
    input  logic             id_mem_r,
    input  logic             id_mem_acc,
    input  logic             br_taken,
    input  logic             mem_ready,
    output logic [1:0]       sel_src1,
    output logic [1:0]       sel_src2,
    output logic             hazard_stall,
    output logic             mem_freeze,
    output logic             flush,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef struct packed {
        logic             valid;
        logic [REG_W-1:0] dest;
        logic             wb_en;
        logic             mem_r;
        logic             mem_acc;
        logic [REG_W-1:0] src1;
        logic [REG_W-1:0] src2;
        logic             use1;
        logic             use2;
    } stage_rec_t;

    stage_rec_t e_q, e_d;
    stage_rec_t m_q, m_d;
    stage_rec_t w_q, w_d;
    stage_rec_t id_rec;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic id_hit_e;
    logic id_hit_m;
    logic load_use;
    logic raw_haz;

    // A producer in M that is a load is never a forwarding source.
    function automatic logic [1:0] fwd_sel(
        input logic             en,
        input stage_rec_t       e,
        input stage_rec_t       m,
        input stage_rec_t       w,
        input logic [REG_W-1:0] src,
        input logic             use_src
    );
        logic [1:0] sel;
        sel = 2'd0;
        if (en && e.valid && use_src) begin
            if (m.valid && m.wb_en && !m.mem_r && m.dest == src)
                sel = 2'd1;
            else if (w.valid && w.wb_en && w.dest == src)
                sel = 2'd2;
        end
        return sel;
    endfunction

    always_comb begin
        id_rec         = '0;
        id_rec.valid   = id_valid;
        id_rec.dest    = id_dest;
        id_rec.wb_en   = id_wb_en;
        id_rec.mem_r   = id_mem_r;
        id_rec.mem_acc = id_mem_acc;
        id_rec.src1    = id_src1;
        id_rec.src2    = id_src2;
        id_rec.use1    = id_use1;
        id_rec.use2    = id_use2;

        id_hit_e = (id_use1 && id_src1 == e_q.dest)
                 || (id_use2 && id_src2 == e_q.dest);
        id_hit_m = (id_use1 && id_src1 == m_q.dest)
                 || (id_use2 && id_src2 == m_q.dest);

        load_use = id_valid && e_q.valid && e_q.mem_r
                 && e_q.wb_en && id_hit_e;
        raw_haz  = id_valid
                 && ((e_q.valid && e_q.wb_en && id_hit_e)
                  || (m_q.valid && m_q.wb_en && id_hit_m));

        mem_freeze   = m_q.valid && m_q.mem_acc && !mem_ready;
        hazard_stall = (fwd_en ? load_use : raw_haz)
                     && !br_taken && !mem_freeze;
        flush        = br_taken && !mem_freeze;

        sel_src1 = fwd_sel(fwd_en, e_q, m_q, w_q, e_q.src1, e_q.use1);
        sel_src2 = fwd_sel(fwd_en, e_q, m_q, w_q, e_q.src2, e_q.use2);
    end

    always_comb begin
        e_d = e_q;
        m_d = m_q;
        w_d = w_q;
        if (!mem_freeze) begin
            w_d = m_q;
            m_d = e_q;
            e_d = (hazard_stall || flush) ? '0 : id_rec;
        end
        cnt_d = cnt_q;
        if ((hazard_stall || mem_freeze) && cnt_q != {CNT_W{1'b1}})
            cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            e_q   <= '0;
            m_q   <= '0;
            w_q   <= '0;
            cnt_q <= '0;
        end else begin
            e_q   <= e_d;
            m_q   <= m_d;
            w_q   <= w_d;
            cnt_q <= cnt_d;
        end
    end

    assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_exe_hazard_fwd_ctrl.sv
// Directed checks for exe_hazard_fwd_ctrl: forwarding, stalls,
// freeze, flush, counter saturation and async reset.
module tb_exe_hazard_fwd_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        fwd_en;
    logic        id_valid;
    logic [3:0]  id_src1;
    logic [3:0]  id_src2;
    logic        id_use1;
    logic        id_use2;
    logic [3:0]  id_dest;
    logic        id_wb_en;
    logic        id_mem_r;
    logic        id_mem_acc;
    logic        br_taken;
    logic        mem_ready;
    logic [1:0]  sel_src1;
    logic [1:0]  sel_src2;
    logic        hazard_stall;
    logic        mem_freeze;
    logic        flush;
    logic [15:0] stall_cnt;

    int n_chk  = 0;
    int n_pass = 0;

    exe_hazard_fwd_ctrl #(.REG_W(4), .CNT_W(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .fwd_en       (fwd_en),
        .id_valid     (id_valid),
        .id_src1      (id_src1),
        .id_src2      (id_src2),
        .id_use1      (id_use1),
        .id_use2      (id_use2),
        .id_dest      (id_dest),
        .id_wb_en     (id_wb_en),
        .id_mem_r     (id_mem_r),
        .id_mem_acc   (id_mem_acc),
        .br_taken     (br_taken),
        .mem_ready    (mem_ready),
        .sel_src1     (sel_src1),
        .sel_src2     (sel_src2),
        .hazard_stall (hazard_stall),
        .mem_freeze   (mem_freeze),
        .flush        (flush),
        .stall_cnt    (stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [3:0] s1,
                          input logic u1, input logic [3:0] s2,
                          input logic u2, input logic [3:0] d,
                          input logic wb, input logic mr,
                          input logic ma);
        id_valid   = v;
        id_src1    = s1;
        id_use1    = u1;
        id_src2    = s2;
        id_use2    = u2;
        id_dest    = d;
        id_wb_en   = wb;
        id_mem_r   = mr;
        id_mem_acc = ma;
        #1;
    endtask

    task automatic idle;
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        rst = 1'b0;
        fwd_en = 1'b1;
        br_taken = 1'b0;
        mem_ready = 1'b1;
        idle();
        #1;
        chk("rst_sel1", {30'd0, sel_src1}, 0);
        chk("rst_sel2", {30'd0, sel_src2}, 0);
        chk("rst_stall", {31'd0, hazard_stall}, 0);
        chk("rst_freeze", {31'd0, mem_freeze}, 0);
        chk("rst_flush", {31'd0, flush}, 0);
        chk("rst_cnt", {16'd0, stall_cnt}, 0);
        tick();
        tick();
        rst = 1'b1;
        #1;

        // load R1 then dependent ADD: one bubble, then WB forward
        set_id(1, 4'd3, 1, 4'd0, 0, 4'd1, 1, 1, 1);
        tick();
        set_id(1, 4'd1, 1, 4'd0, 0, 4'd4, 1, 0, 0);
        chk("lu_stall", {31'd0, hazard_stall}, 1);
        tick();
        chk("lu_stall_gone", {31'd0, hazard_stall}, 0);
        tick();
        idle();
        chk("lu_sel1_wb", {30'd0, sel_src1}, 2);
        chk("lu_sel2", {30'd0, sel_src2}, 0);
        chk("lu_cnt", {16'd0, stall_cnt}, 1);

        // two ALU producers of R2, consumer on src2: MEM wins
        set_id(1, 4'd0, 0, 4'd0, 0, 4'd2, 1, 0, 0);
        tick();
        set_id(1, 4'd0, 0, 4'd0, 0, 4'd2, 1, 0, 0);
        tick();
        set_id(1, 4'd0, 0, 4'd2, 1, 4'd5, 1, 0, 0);
        chk("alu_nostall", {31'd0, hazard_stall}, 0);
        tick();
        idle();
        chk("alu_sel2_mem", {30'd0, sel_src2}, 1);
        chk("alu_sel1", {30'd0, sel_src1}, 0);
        fwd_en = 1'b0;
        #1;
        chk("nofwd_sel2", {30'd0, sel_src2}, 0);
        tick();
        tick();
        tick();

        // no forwarding: RAW against E then M stalls two cycles
        set_id(1, 4'd0, 0, 4'd0, 0, 4'd2, 1, 0, 0);
        tick();
        set_id(1, 4'd2, 1, 4'd2, 1, 4'd6, 1, 0, 0);
        chk("raw_stall_e", {31'd0, hazard_stall}, 1);
        chk("raw_sel1", {30'd0, sel_src1}, 0);
        tick();
        chk("raw_stall_m", {31'd0, hazard_stall}, 1);
        chk("raw_sel2", {30'd0, sel_src2}, 0);
        tick();
        chk("raw_wb_nostall", {31'd0, hazard_stall}, 0);
        chk("raw_cnt", {16'd0, stall_cnt}, 3);
        tick();
        idle();
        fwd_en = 1'b1;
        tick();
        tick();

        // store in M freezes; W producer feeding E must stay put
        set_id(1, 4'd0, 0, 4'd0, 0, 4'd9, 1, 0, 0);
        tick();
        set_id(1, 4'd7, 1, 4'd8, 1, 4'd0, 0, 0, 1);
        tick();
        set_id(1, 4'd9, 1, 4'd0, 0, 4'd10, 1, 0, 0);
        tick();
        set_id(1, 4'd10, 1, 4'd0, 0, 4'd11, 1, 0, 0);
        chk("pre_frz_sel1", {30'd0, sel_src1}, 2);
        mem_ready = 1'b0;
        br_taken = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("frz_on", {31'd0, mem_freeze}, 1);
            chk("frz_flush", {31'd0, flush}, 0);
            chk("frz_stall", {31'd0, hazard_stall}, 0);
            chk("frz_sel1_hold", {30'd0, sel_src1}, 2);
            tick();
        end
        mem_ready = 1'b1;
        br_taken = 1'b0;
        #1;
        chk("frz_off", {31'd0, mem_freeze}, 0);
        chk("frz_cnt", {16'd0, stall_cnt}, 6);
        idle();
        tick();
        tick();
        tick();

        // taken branch beats load-use; squashed ID leaves E empty
        set_id(1, 4'd0, 0, 4'd0, 0, 4'd3, 1, 1, 1);
        tick();
        set_id(1, 4'd3, 1, 4'd0, 0, 4'd5, 1, 1, 1);
        chk("br_pre_stall", {31'd0, hazard_stall}, 1);
        br_taken = 1'b1;
        #1;
        chk("br_flush", {31'd0, flush}, 1);
        chk("br_stall", {31'd0, hazard_stall}, 0);
        tick();
        br_taken = 1'b0;
        set_id(1, 4'd5, 1, 4'd0, 0, 4'd6, 1, 0, 0);
        chk("br_e_bubble", {31'd0, hazard_stall}, 0);
        chk("br_cnt", {16'd0, stall_cnt}, 6);
        idle();
        tick();
        tick();
        tick();

        // long freeze drives the counter into saturation
        set_id(1, 4'd0, 0, 4'd0, 0, 4'd0, 0, 0, 1);
        tick();
        idle();
        tick();
        mem_ready = 1'b0;
        #1;
        chk("sat_frz", {31'd0, mem_freeze}, 1);
        for (int i = 0; i < 65540; i++) tick();
        chk("sat_max", {16'd0, stall_cnt}, 32'hFFFF);
        tick();
        chk("sat_hold", {16'd0, stall_cnt}, 32'hFFFF);

        // async reset in the middle of the freeze
        #2;
        rst = 1'b0;
        #1;
        chk("arst_frz", {31'd0, mem_freeze}, 0);
        chk("arst_cnt", {16'd0, stall_cnt}, 0);
        chk("arst_sel1", {30'd0, sel_src1}, 0);
        tick();
        rst = 1'b1;
        #1;
        chk("post_rst_frz", {31'd0, mem_freeze}, 0);
        mem_ready = 1'b1;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
